// File: rtl/instr_fetch_queue_pkg.sv
// Shared types and constants for the instruction fetch queue.
package instr_fetch_queue_pkg;

    localparam int unsigned ADDR_W = 15;

    localparam logic [ADDR_W-1:0] FETCH_RESET_PC = 15'o4000;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [ADDR_W-1:0] instr;
    } fetch_entry_t;

    // Word addresses wrap modulo 2^ADDR_W.
    function automatic logic [ADDR_W-1:0] pc_inc(input logic [ADDR_W-1:0] pc);
        return pc + ADDR_W'(1);
    endfunction

endpackage

// File: rtl/instr_fetch_queue_fifo.sv
// Circular queue of fetched words with flush; the head is masked to zero when empty.
module fetch_fifo
    import instr_fetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  fetch_entry_t             push_data_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    output fetch_entry_t             head_o,
    output logic                     valid_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    fetch_entry_t   mem_q [DEPTH];
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic           full;
    logic           do_push;
    logic           do_pop;

    always_comb begin
        full     = (count_q == CW'(DEPTH));
        do_pop   = pop_i && (count_q != '0);
        do_push  = push_i && (!full || do_pop);
        wr_ptr_d = wr_ptr_q + PW'(do_push);
        rd_ptr_d = rd_ptr_q + PW'(do_pop);
        count_d  = count_q + CW'(do_push) - CW'(do_pop);
        // Flush wins over any push or pop arriving in the same cycle.
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    always_comb begin
        valid_o = (count_q != '0);
        count_o = count_q;
        head_o  = valid_o ? mem_q[rd_ptr_q] : '0;
    end

endmodule

// File: rtl/instr_fetch_queue.sv
// Instruction fetch: issues one ROM read per cycle while there is room, queues the
// tagged responses and squashes everything in flight on a branch redirect.
module instr_fetch_queue
    import instr_fetch_queue_pkg::*;
#(
    parameter int unsigned        DEPTH    = 4,
    parameter logic [ADDR_W-1:0]  RESET_PC = FETCH_RESET_PC
) (
    input  logic                     clock,
    input  logic                     reset,
    output logic [ADDR_W-1:0]        ROM_address,
    output logic                     ROM_read_en,
    input  logic [ADDR_W-1:0]        ROM_read_data,
    input  logic                     redirect,
    input  logic [ADDR_W-1:0]        redirect_pc,
    output logic                     instr_valid,
    output logic [ADDR_W-1:0]        instr,
    output logic [ADDR_W-1:0]        instr_pc,
    input  logic                     instr_ready,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] req_pc_q, req_pc_d;
    logic              inflight_q, inflight_d;
    logic [CW-1:0]     fifo_count;
    logic [CW-1:0]     occupancy;
    logic              can_issue;
    logic              issue;
    logic              push;
    logic              pop;
    fetch_entry_t      push_entry;
    fetch_entry_t      head_entry;
    logic              head_valid;

    always_comb begin
        // Pops in the current cycle are deliberately not credited to the guard.
        occupancy   = fifo_count + CW'(inflight_q);
        can_issue   = (occupancy < CW'(DEPTH));
        issue       = !reset && (redirect || can_issue);
        ROM_read_en = issue;
        ROM_address = redirect ? redirect_pc : fetch_pc_q;
        fetch_pc_d  = issue ? pc_inc(ROM_address) : fetch_pc_q;
        req_pc_d    = issue ? ROM_address : req_pc_q;
        inflight_d  = issue;
        push        = inflight_q && !redirect;
        pop         = instr_ready && !redirect;
        push_entry  = '{pc: req_pc_q, instr: ROM_read_data};
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= '0;
            inflight_q <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
            inflight_q <= inflight_d;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i       (clock),
        .rst_i       (reset),
        .push_i      (push),
        .push_data_i (push_entry),
        .pop_i       (pop),
        .flush_i     (redirect),
        .head_o      (head_entry),
        .valid_o     (head_valid),
        .count_o     (fifo_count)
    );

    always_comb begin
        instr_valid = head_valid;
        instr       = head_entry.instr;
        instr_pc    = head_entry.pc;
        count       = fifo_count;
    end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Bench for instr_fetch_queue: per-cycle vector table plus scoreboarded stream sequences.
module tb_instr_fetch_queue;
    import instr_fetch_queue_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;
    localparam logic [14:0] KEY   = 15'o1234;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic [14:0]       ROM_address;
    logic              ROM_read_en;
    logic [14:0]       ROM_read_data = '0;
    logic              redirect = 1'b0;
    logic [14:0]       redirect_pc = '0;
    logic              instr_valid;
    logic [14:0]       instr;
    logic [14:0]       instr_pc;
    logic              instr_ready = 1'b0;
    logic [CW-1:0]     count;

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    always #5 clock = ~clock;

    always @(posedge clock) ROM_read_data <= ROM_address ^ KEY;

    instr_fetch_queue #(
        .DEPTH    (DEPTH),
        .RESET_PC (15'o4000)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .ROM_address   (ROM_address),
        .ROM_read_en   (ROM_read_en),
        .ROM_read_data (ROM_read_data),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .instr_valid   (instr_valid),
        .instr         (instr),
        .instr_pc      (instr_pc),
        .instr_ready   (instr_ready),
        .count         (count)
    );

    typedef struct {
        logic        rst;
        logic        redir;
        logic [14:0] rpc;
        logic        rdy;
        logic        e_en;
        logic [14:0] e_addr;
        logic        e_v;
        logic [14:0] e_pc;
        int unsigned e_cnt;
    } vec_t;

    vec_t         tbl[$];
    fetch_entry_t exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0o, expected %0o", name, act, exp);
        end
    endtask

    task automatic consume(input string tag);
        fetch_entry_t e;
        n_vec++;
        if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL %s.extra_output: got pc %0o, expected no further output", tag, instr_pc);
        end else begin
            n_vec--;
            e = exp_q.pop_front();
            check({tag, ".instr_pc"}, 32'(instr_pc), 32'(e.pc));
            check({tag, ".instr"}, 32'(instr), 32'(e.instr));
        end
    endtask

    function automatic vec_t mk(input logic rst, input logic redir, input logic [14:0] rpc,
                                input logic rdy, input logic en, input logic [14:0] addr,
                                input logic v, input logic [14:0] pc, input int unsigned cnt);
        vec_t r;
        r.rst = rst; r.redir = redir; r.rpc = rpc; r.rdy = rdy;
        r.e_en = en; r.e_addr = addr; r.e_v = v; r.e_pc = pc; r.e_cnt = cnt;
        return r;
    endfunction

    function automatic void load_stream(input logic [14:0] start, input int unsigned n);
        logic [14:0] pc;
        exp_q.delete();
        pc = start;
        for (int unsigned k = 0; k < n; k++) begin
            exp_q.push_back('{pc: pc, instr: pc ^ KEY});
            pc = pc + 15'd1;
        end
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int first_issue;
        int first_valid;
        int unsigned popped;

        // rst redir rpc rdy | en addr v pc cnt
        // Stall: four requests, then the queue saturates with 'o4000 at the head
        tbl.push_back(mk(1, 0, 0,       0, 0, 0,       0, 0,       0));
        tbl.push_back(mk(0, 0, 0,       0, 1, 15'o4000, 0, 0,       0));
        tbl.push_back(mk(0, 0, 0,       0, 1, 15'o4001, 0, 0,       0));
        tbl.push_back(mk(0, 0, 0,       0, 1, 15'o4002, 1, 15'o4000, 1));
        tbl.push_back(mk(0, 0, 0,       0, 1, 15'o4003, 1, 15'o4000, 2));
        tbl.push_back(mk(0, 0, 0,       0, 0, 0,       1, 15'o4000, 3));
        tbl.push_back(mk(0, 0, 0,       0, 0, 0,       1, 15'o4000, 4));
        tbl.push_back(mk(0, 0, 0,       0, 0, 0,       1, 15'o4000, 4));
        // Redirect with 3 queued and 1 in flight
        tbl.push_back(mk(1, 0, 0,       0, 0, 0,       0, 0,       0));
        tbl.push_back(mk(0, 0, 0,       0, 1, 15'o4000, 0, 0,       0));
        tbl.push_back(mk(0, 0, 0,       0, 1, 15'o4001, 0, 0,       0));
        tbl.push_back(mk(0, 0, 0,       0, 1, 15'o4002, 1, 15'o4000, 1));
        tbl.push_back(mk(0, 0, 0,       0, 1, 15'o4003, 1, 15'o4000, 2));
        tbl.push_back(mk(0, 1, 15'o2000, 0, 1, 15'o2000, 1, 15'o4000, 3));
        tbl.push_back(mk(0, 0, 0,       0, 1, 15'o2001, 0, 0,       0));
        tbl.push_back(mk(0, 0, 0,       1, 1, 15'o2002, 1, 15'o2000, 1));
        tbl.push_back(mk(0, 0, 0,       1, 1, 15'o2003, 1, 15'o2001, 1));
        // Redirect coinciding with a pop; then a pop on an empty queue
        tbl.push_back(mk(0, 1, 15'o3000, 1, 1, 15'o3000, 1, 15'o2002, 1));
        tbl.push_back(mk(0, 0, 0,       1, 1, 15'o3001, 0, 0,       0));
        tbl.push_back(mk(0, 0, 0,       0, 1, 15'o3002, 1, 15'o3000, 1));
        tbl.push_back(mk(0, 0, 0,       0, 1, 15'o3003, 1, 15'o3000, 2));
        // Back-to-back redirects: only the second target survives
        tbl.push_back(mk(0, 1, 15'o1000, 0, 1, 15'o1000, 1, 15'o3000, 3));
        tbl.push_back(mk(0, 1, 15'o1100, 0, 1, 15'o1100, 0, 0,       0));
        tbl.push_back(mk(0, 0, 0,       0, 1, 15'o1101, 0, 0,       0));
        tbl.push_back(mk(0, 0, 0,       0, 1, 15'o1102, 1, 15'o1100, 1));

        @(posedge clock); #1;
        foreach (tbl[i]) begin
            reset       = tbl[i].rst;
            redirect    = tbl[i].redir;
            redirect_pc = tbl[i].rpc;
            instr_ready = tbl[i].rdy;
            @(negedge clock);
            check($sformatf("v%0d.ROM_read_en", i), 32'(ROM_read_en), 32'(tbl[i].e_en));
            if (tbl[i].e_en)
                check($sformatf("v%0d.ROM_address", i), 32'(ROM_address), 32'(tbl[i].e_addr));
            check($sformatf("v%0d.instr_valid", i), 32'(instr_valid), 32'(tbl[i].e_v));
            if (tbl[i].e_v) begin
                check($sformatf("v%0d.instr_pc", i), 32'(instr_pc), 32'(tbl[i].e_pc));
                check($sformatf("v%0d.instr", i), 32'(instr), 32'(tbl[i].e_pc ^ KEY));
            end
            if (tbl[i].rst) begin
                check($sformatf("v%0d.reset_instr", i), 32'(instr), 32'(0));
                check($sformatf("v%0d.reset_instr_pc", i), 32'(instr_pc), 32'(0));
            end
            check($sformatf("v%0d.count", i), 32'(count), tbl[i].e_cnt);
            @(posedge clock); #1;
        end
        redirect = 1'b0;

        // Streaming from reset with decode always ready
        reset = 1'b1; instr_ready = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        load_stream(15'o4000, 24);
        first_issue = -1; first_valid = -1; popped = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge clock);
            if (ROM_read_en && first_issue < 0) first_issue = cyc;
            if (instr_valid && first_valid < 0) first_valid = cyc;
            if (instr_valid && instr_ready) begin
                consume("stream");
                popped++;
            end
            @(posedge clock); #1;
        end
        check("stream.first_issue_cycle", 32'(first_issue), 32'(0));
        check("stream.issue_to_valid", 32'(first_valid - first_issue), 32'(2));
        check("stream.popped", popped, 32'(18));

        // Redirect near the top of the address space
        redirect = 1'b1; redirect_pc = 15'o77776;
        @(negedge clock);
        check("wrap.ROM_read_en", 32'(ROM_read_en), 32'(1));
        check("wrap.ROM_address", 32'(ROM_address), 32'(15'o77776));
        @(posedge clock); #1;
        redirect = 1'b0;
        exp_q.delete();
        exp_q.push_back('{pc: 15'o77776, instr: 15'o77776 ^ KEY});
        exp_q.push_back('{pc: 15'o77777, instr: 15'o77777 ^ KEY});
        exp_q.push_back('{pc: 15'o00000, instr: 15'o00000 ^ KEY});
        exp_q.push_back('{pc: 15'o00001, instr: 15'o00001 ^ KEY});
        for (int cyc = 0; cyc < 20 && exp_q.size() > 0; cyc++) begin
            @(negedge clock);
            if (instr_valid && instr_ready) consume("wrap");
            @(posedge clock); #1;
        end
        check("wrap.remaining", exp_q.size(), 32'(0));

        // One-cycle reset in the middle of the stream
        check("midrst.pre_valid", 32'(instr_valid), 32'(1));
        reset = 1'b1;
        #1;
        check("midrst.valid_drop", 32'(instr_valid), 32'(0));
        check("midrst.count", 32'(count), 32'(0));
        @(negedge clock);
        check("midrst.ROM_read_en", 32'(ROM_read_en), 32'(0));
        @(posedge clock); #1;
        reset = 1'b0;
        load_stream(15'o4000, 8);
        @(negedge clock);
        check("midrst.restart_en", 32'(ROM_read_en), 32'(1));
        check("midrst.restart_addr", 32'(ROM_address), 32'(15'o4000));
        for (int cyc = 0; cyc < 6; cyc++) begin
            @(posedge clock); #1;
            @(negedge clock);
            if (instr_valid && instr_ready) consume("midrst");
        end
        check("midrst.consumed", exp_q.size(), 32'(3));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
